// File: rtl/mips_lsu_pkg.sv
// Shared types and decode helpers for the MIPS load/store unit.
// Operation encoding, FSM states and the alignment rules live here so the top and formatter agree.
package mips_lsu_pkg;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SB  = 4'd8,
        SH  = 4'd9,
        SW  = 4'd10
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } lsu_state_t;

    function automatic logic is_load(lsu_op_t op);
        return op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
    endfunction

    function automatic logic is_store(lsu_op_t op);
        return op inside {SB, SH, SW};
    endfunction

    // LWL/LWR are unaligned by design and never fault.
    function automatic logic misaligned(lsu_op_t op, logic [1:0] off);
        case (op)
            LH, LHU, SH: return off[0];
            LW, SW:      return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_load_store_unit_if.sv
// Core-side request/response handshake plus the word-wide memory port of the LSU.
// slave is the LSU's view; master is the core's view of the request/response half.
interface mips_load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mips_lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    lsu_op_t           req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] resp_badaddr;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_read_en;
    logic              mem_wr_en;
    logic [3:0]        mem_byte_en;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_badaddr,
        output mem_address, mem_read_en, mem_wr_en, mem_byte_en, mem_data_in
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_badaddr
    );

endinterface

// File: rtl/mips_lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/halfword out of a big-endian word,
// extends it, or merges the word into the old rt for LWL/LWR.
module mips_lsu_load_align
    import mips_lsu_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] rt,
    output logic [31:0] result
);

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic [4:0]  lsh;
    logic [4:0]  rsh;
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Offset 0 is the most significant byte, so a right shift of 8*(3-o) brings it to [7:0].
    assign lsh     = {off, 3'b000};
    assign rsh     = {~off, 3'b000};
    assign shifted = word >> rsh;
    assign byte_v  = shifted[7:0];
    assign half_v  = (off == 2'b00) ? word[31:16] : word[15:0];

    always_comb begin
        result = '0;
        case (op)
            LB:      result = {{24{byte_v[7]}}, byte_v};
            LBU:     result = {24'h0, byte_v};
            LH:      result = {{16{half_v[15]}}, half_v};
            LHU:     result = {16'h0, half_v};
            LW:      result = word;
            LWL:     result = (word << lsh) | (rt & ~(ONES << lsh));
            LWR:     result = (word >> rsh) | (rt & ~(ONES >> rsh));
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// MIPS load/store unit: accepts one operation per handshake, drives the memory port in the
// accept cycle, formats load data one cycle later and returns a single-cycle response.
module mips_load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    mips_load_store_unit_if.slave bus
);

    lsu_state_t state, next_state;

    logic              accept;
    logic [1:0]        off;
    logic              req_is_load;
    logic              req_is_store;
    logic              req_misaligned;
    logic [3:0]        store_be;
    logic [DATA_W-1:0] store_data;

    lsu_op_t           op_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] rt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [ADDR_W-1:0] badaddr_q;
    logic [DATA_W-1:0] load_result;

    assign off            = bus.req_addr[1:0];
    assign req_is_load    = is_load(bus.req_op);
    assign req_is_store   = is_store(bus.req_op);
    assign req_misaligned = misaligned(bus.req_op, off);

    always_comb begin
        store_be   = 4'b0000;
        store_data = '0;
        case (bus.req_op)
            SB: begin
                store_be   = 4'b1000 >> off;
                store_data = {4{bus.req_wdata[7:0]}};
            end
            SH: begin
                store_be   = (off == 2'b00) ? 4'b1100 : 4'b0011;
                store_data = {2{bus.req_wdata[15:0]}};
            end
            SW: begin
                store_be   = 4'b1111;
                store_data = bus.req_wdata;
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state       = state;
        accept           = 1'b0;
        bus.req_ready    = (state == IDLE);
        bus.mem_read_en  = 1'b0;
        bus.mem_wr_en    = 1'b0;
        bus.mem_byte_en  = 4'b0000;
        bus.mem_data_in  = '0;
        case (state)
            IDLE: begin
                // rst_n gating keeps the strobes quiet while reset holds the FSM in IDLE.
                if (bus.req_valid && rst_n) begin
                    accept = 1'b1;
                    if (req_misaligned) begin
                        next_state = RESP;
                    end else if (req_is_load) begin
                        bus.mem_read_en = 1'b1;
                        next_state      = RD_WAIT;
                    end else begin
                        if (req_is_store) begin
                            bus.mem_wr_en   = 1'b1;
                            bus.mem_byte_en = store_be;
                            bus.mem_data_in = store_data;
                        end
                        next_state = RESP;
                    end
                end
            end
            RD_WAIT: next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= LB;
            off_q     <= 2'b00;
            rt_q      <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            badaddr_q <= '0;
        end else if (accept) begin
            op_q      <= bus.req_op;
            off_q     <= off;
            rt_q      <= bus.req_wdata;
            rdata_q   <= '0;
            err_q     <= req_misaligned;
            badaddr_q <= req_misaligned ? bus.req_addr : '0;
        end else if (state == RD_WAIT) begin
            rdata_q   <= load_result;
        end
    end

    mips_lsu_load_align u_load_align (
        .op     (op_q),
        .off    (off_q),
        .word   (bus.mem_data_out),
        .rt     (rt_q),
        .result (load_result)
    );

    assign bus.mem_address  = {bus.req_addr[ADDR_W-1:2], 2'b00};
    assign bus.resp_valid   = (state == RESP);
    assign bus.resp_err     = (state == RESP) && err_q;
    assign bus.resp_rdata   = rdata_q;
    assign bus.resp_badaddr = badaddr_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Self-checking bench for mips_load_store_unit: a word-wide memory responder plus a
// byte-array reference model of big-endian memory and MIPS load/store semantics.
module tb_mips_load_store_unit;
    import mips_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    mips_load_store_unit_if bus ();

    mips_load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory responder: 16 words covering byte addresses 0x100..0x13F.
    logic [31:0] mem_words [16];

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_read_en) bus.mem_data_out <= mem_words[bus.mem_address[5:2]];
        if (bus.mem_wr_en)
            mem_words[bus.mem_address[5:2]] <= merge(mem_words[bus.mem_address[5:2]],
                                                     bus.mem_data_in, bus.mem_byte_en);
    end

    // Reference model: memory as individual bytes, byte address a -> ref_mem[a[5:0]].
    logic [7:0] ref_mem [64];

    function automatic logic [31:0] ref_load(lsu_op_t op, logic [31:0] addr, logic [31:0] rt);
        int a    = int'(addr[5:0]);
        int o    = int'(addr[1:0]);
        int base = a - o;
        logic [31:0] r = '0;
        case (op)
            LB:  r = {{24{ref_mem[a][7]}}, ref_mem[a]};
            LBU: r = {24'h0, ref_mem[a]};
            LH:  r = {{16{ref_mem[a][7]}}, ref_mem[a], ref_mem[a+1]};
            LHU: r = {16'h0, ref_mem[a], ref_mem[a+1]};
            LW:  r = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
            LWL: begin
                r = rt;
                for (int k = o; k < 4; k++) r[8*(3-(k-o)) +: 8] = ref_mem[base+k];
            end
            LWR: begin
                r = rt;
                for (int k = 0; k <= o; k++) r[8*(o-k) +: 8] = ref_mem[base+k];
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction; leaves the bench on a negedge with the LSU back in IDLE.
    task automatic do_op(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] rt,
                         output logic [31:0] rdata);
        bit          ld  = op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
        bit          st  = op inside {SB, SH, SW};
        bit          mis = ((op inside {LH, LHU, SH}) && addr[0]) ||
                           ((op inside {LW, SW}) && addr[1:0] != 2'b00);
        int          o   = int'(addr[1:0]);
        logic [3:0]  exp_be = 4'b0000;
        logic [31:0] exp_data = '0;
        logic [31:0] exp_rdata = '0;
        int          exp_lat = (ld && !mis) ? 2 : 1;
        int          guard = 0;
        int          lat = 0;

        while (!bus.req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_before_op", 32'(bus.req_ready), 32'd1);

        if (st && !mis) begin
            case (op)
                SB: begin exp_be[3-o] = 1'b1; exp_data = {4{rt[7:0]}}; end
                SH: begin exp_be[3-o] = 1'b1; exp_be[2-o] = 1'b1; exp_data = {2{rt[15:0]}}; end
                default: begin exp_be = 4'b1111; exp_data = rt; end
            endcase
        end
        if (ld && !mis) exp_rdata = ref_load(op, addr, rt);

        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = rt;
        #1;
        check("mem_read_en", 32'(bus.mem_read_en), 32'(ld && !mis));
        check("mem_wr_en",   32'(bus.mem_wr_en),   32'(st && !mis));
        check("mem_byte_en", 32'(bus.mem_byte_en), 32'(exp_be));
        check("mem_address", bus.mem_address, {addr[31:2], 2'b00});
        if (st && !mis) check("mem_data_in", bus.mem_data_in, exp_data);

        if (st && !mis) begin
            case (op)
                SB: ref_mem[addr[5:0]] = rt[7:0];
                SH: begin ref_mem[addr[5:0]] = rt[15:8]; ref_mem[addr[5:0]+1] = rt[7:0]; end
                default: for (int k = 0; k < 4; k++) ref_mem[addr[5:0]+k] = rt[31-8*k -: 8];
            endcase
        end

        @(posedge clk);
        #1;
        // A request presented while busy must be ignored.
        bus.req_op   = SW;
        bus.req_addr = 32'h0000_0130;
        while (lat < 5) begin
            @(negedge clk);
            lat++;
            check("busy_no_write", 32'(bus.mem_wr_en | bus.mem_read_en), 32'd0);
            if (bus.resp_valid) break;
            check("busy_not_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        check("resp_latency", 32'(lat), 32'(exp_lat));
        check("resp_err",     32'(bus.resp_err), 32'(mis));
        check("resp_rdata",   bus.resp_rdata, exp_rdata);
        if (mis) check("resp_badaddr", bus.resp_badaddr, addr);
        rdata = bus.resp_rdata;

        @(negedge clk);
        check("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
        check("ready_after",    32'(bus.req_ready),  32'd1);
    endtask

    lsu_op_t ops [10] = '{LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW};

    initial begin
        logic [31:0] r;
        int guard;

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = LW;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        #1;
        check("rst_ready",     32'(bus.req_ready),    32'd1);
        check("rst_valid",     32'(bus.resp_valid),   32'd0);
        check("rst_err",       32'(bus.resp_err),     32'd0);
        check("rst_rdata",     bus.resp_rdata,        32'd0);
        check("rst_badaddr",   bus.resp_badaddr,      32'd0);
        check("rst_strobes",   32'({bus.mem_read_en, bus.mem_wr_en, bus.mem_byte_en}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill memory through the DUT so responder and model start identical.
        for (int i = 0; i < 16; i++) do_op(SW, 32'h100 + 32'(4*i), $urandom, r);

        // Directed cases.
        do_op(SW, 32'h100, 32'hDEADBEEF, r);
        do_op(SB, 32'h103, 32'h000000A5, r);
        do_op(LBU, 32'h103, 32'h0, r);            check("spec_lbu_a5", r, 32'h0000_00A5);
        do_op(SW, 32'h110, 32'h80FF7F01, r);
        do_op(LB,  32'h110, 32'h0, r);            check("spec_lb",  r, 32'hFFFF_FF80);
        do_op(LBU, 32'h110, 32'h0, r);            check("spec_lbu", r, 32'h0000_0080);
        do_op(LH,  32'h112, 32'h0, r);            check("spec_lh",  r, 32'h0000_7F01);
        do_op(LHU, 32'h110, 32'h0, r);            check("spec_lhu", r, 32'h0000_80FF);
        do_op(SW, 32'h120, 32'h11223344, r);
        do_op(LWL, 32'h121, 32'hAABBCCDD, r);     check("spec_lwl", r, 32'h2233_44DD);
        do_op(LWR, 32'h121, 32'hAABBCCDD, r);     check("spec_lwr", r, 32'hAABB_1122);
        do_op(LW, 32'h102, 32'h0, r);
        do_op(SH, 32'h101, 32'h1234, r);
        do_op(LW, 32'h100, 32'h0, r);             check("spec_lw_after_sh", r, 32'hDEAD_BEA5);

        // Reset while a load sits in RD_WAIT.
        bus.req_valid = 1'b1;
        bus.req_op    = LW;
        bus.req_addr  = 32'h104;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.resp_valid), 32'd0);
        check("midrst_ready", 32'(bus.req_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        guard = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) guard++;
        end
        check("midrst_no_resp", 32'(guard), 32'd0);
        do_op(SW, 32'h104, 32'hCAFEF00D, r);
        do_op(LW, 32'h104, 32'h0, r);             check("midrst_followup", r, 32'hCAFE_F00D);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            lsu_op_t op = ops[$urandom_range(0, 9)];
            do_op(op, 32'h100 + 32'($urandom_range(0, 63)), $urandom, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
